// File: rtl/interval_counter.sv
// Interval counter for tag-side timing: counts enabled cycles, saturating or
// wrapping at a run-time limit, with a capture strobe for back-to-back intervals.
module interval_counter #(
    parameter int WIDTH     = 10,
    parameter int WRAP_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    input  logic             capture,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] captured,
    output logic             captured_ovf,
    output logic             captured_valid
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap_pulse;
    logic [WIDTH-1:0] r_captured;
    logic             r_captured_ovf;
    logic             r_captured_valid;

    logic             w_overflow;
    logic             w_all_ones;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;

    // Overflow only exists in saturate mode and follows limit with no latency.
    assign w_overflow = (WRAP_MODE != 0) ? 1'b0 : (r_count > limit);
    assign w_all_ones = &r_count;

    // Enabled-count update; all-ones guard keeps the increment from carrying out.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (enable) begin
            if (WRAP_MODE != 0) begin
                if (r_count >= limit) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else if (!w_overflow && !w_all_ones) begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end
    end

    // Priority: reset > clear > capture > enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count          <= '0;
            r_wrap_pulse     <= 1'b0;
            r_captured       <= '0;
            r_captured_ovf   <= 1'b0;
            r_captured_valid <= 1'b0;
        end else if (clear) begin
            r_count          <= '0;
            r_wrap_pulse     <= 1'b0;
            r_captured_valid <= 1'b0;
        end else if (capture) begin
            r_captured       <= r_count;
            r_captured_ovf   <= w_overflow;
            r_count          <= '0;
            r_wrap_pulse     <= 1'b0;
            r_captured_valid <= 1'b1;
        end else begin
            r_count          <= w_count_nxt;
            r_wrap_pulse     <= w_wrap_nxt;
            r_captured_valid <= 1'b0;
        end
    end

    assign count          = r_count;
    assign overflow       = w_overflow;
    assign wrap_pulse     = r_wrap_pulse;
    assign captured       = r_captured;
    assign captured_ovf   = r_captured_ovf;
    assign captured_valid = r_captured_valid;

endmodule

// File: tb/tb_interval_counter.sv
// Directed bench for interval_counter: saturate (WIDTH 10 and 4) and wrap
// instances driven through a linear sequence of steps with fixed expectations.
module tb_interval_counter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: WIDTH=10 saturate
    logic       a_clear, a_en, a_cap;
    logic [9:0] a_limit;
    logic [9:0] a_count, a_captured;
    logic       a_ovf, a_wp, a_cov, a_cv;

    // Instance B: WIDTH=10 wrap
    logic       b_clear, b_en, b_cap;
    logic [9:0] b_limit;
    logic [9:0] b_count, b_captured;
    logic       b_ovf, b_wp, b_cov, b_cv;

    // Instance C: WIDTH=4 saturate
    logic       c_clear, c_en, c_cap;
    logic [3:0] c_limit;
    logic [3:0] c_count, c_captured;
    logic       c_ovf, c_wp, c_cov, c_cv;

    int n_cmp  = 0;
    int n_fail = 0;

    interval_counter #(.WIDTH(10), .WRAP_MODE(0)) u_a (
        .clk(clk), .reset(reset), .clear(a_clear), .enable(a_en), .limit(a_limit),
        .capture(a_cap), .count(a_count), .overflow(a_ovf), .wrap_pulse(a_wp),
        .captured(a_captured), .captured_ovf(a_cov), .captured_valid(a_cv)
    );

    interval_counter #(.WIDTH(10), .WRAP_MODE(1)) u_b (
        .clk(clk), .reset(reset), .clear(b_clear), .enable(b_en), .limit(b_limit),
        .capture(b_cap), .count(b_count), .overflow(b_ovf), .wrap_pulse(b_wp),
        .captured(b_captured), .captured_ovf(b_cov), .captured_valid(b_cv)
    );

    interval_counter #(.WIDTH(4), .WRAP_MODE(0)) u_c (
        .clk(clk), .reset(reset), .clear(c_clear), .enable(c_en), .limit(c_limit),
        .capture(c_cap), .count(c_count), .overflow(c_ovf), .wrap_pulse(c_wp),
        .captured(c_captured), .captured_ovf(c_cov), .captured_valid(c_cv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        a_clear = 1'b0; a_en = 1'b0; a_cap = 1'b0; a_limit = 10'd750;
        b_clear = 1'b0; b_en = 1'b0; b_cap = 1'b0; b_limit = 10'd4;
        c_clear = 1'b0; c_en = 1'b0; c_cap = 1'b0; c_limit = 4'd15;
        tick();
        tick();

        // Reset state
        check("rst_a_count", 32'(a_count), 0);
        check("rst_a_ovf", 32'(a_ovf), 0);
        check("rst_a_cap", 32'(a_captured), 0);
        check("rst_a_cov", 32'(a_cov), 0);
        check("rst_a_cv", 32'(a_cv), 0);
        check("rst_b_count", 32'(b_count), 0);
        check("rst_b_wp", 32'(b_wp), 0);
        check("rst_c_count", 32'(c_count), 0);

        // T1: count 0..751 then saturate with overflow
        reset = 1'b0;
        a_en  = 1'b1;
        for (int i = 1; i <= 751; i++) begin
            tick();
            check("t1_count", 32'(a_count), i);
            check("t1_ovf", 32'(a_ovf), (i > 750) ? 1 : 0);
        end
        for (int i = 0; i < 22; i++) begin
            tick();
            check("t1_hold_count", 32'(a_count), 751);
            check("t1_hold_ovf", 32'(a_ovf), 1);
            check("t1_wp", 32'(a_wp), 0);
        end

        // T2: capture at saturation
        a_cap = 1'b1;
        tick();
        a_cap = 1'b0;
        check("t2_captured", 32'(a_captured), 751);
        check("t2_cov", 32'(a_cov), 1);
        check("t2_cv", 32'(a_cv), 1);
        check("t2_count", 32'(a_count), 0);
        check("t2_ovf", 32'(a_ovf), 0);
        tick();
        check("t2_resume_count", 32'(a_count), 1);
        check("t2_cv_drop", 32'(a_cv), 0);
        check("t2_captured_hold", 32'(a_captured), 751);

        // T4: limit lowered below count, then raised
        for (int i = 2; i <= 300; i++) tick();
        check("t4_count300", 32'(a_count), 300);
        a_limit = 10'd100;
        #1;
        check("t4_ovf_same_cycle", 32'(a_ovf), 1);
        tick();
        check("t4_hold1", 32'(a_count), 300);
        tick();
        check("t4_hold2", 32'(a_count), 300);
        a_limit = 10'd500;
        #1;
        check("t4_ovf_drop", 32'(a_ovf), 0);
        for (int i = 301; i <= 501; i++) begin
            tick();
            check("t4_count", 32'(a_count), i);
        end
        check("t4_ovf_sat", 32'(a_ovf), 1);
        tick();
        check("t4_sat_hold", 32'(a_count), 501);
        check("t4_wp", 32'(a_wp), 0);

        // T5: clear, then clear+capture together at 37, then reset mid-count
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("t5_clear_count", 32'(a_count), 0);
        check("t5_clear_ovf", 32'(a_ovf), 0);
        for (int i = 1; i <= 37; i++) tick();
        check("t5_count37", 32'(a_count), 37);
        a_clear = 1'b1;
        a_cap   = 1'b1;
        tick();
        a_clear = 1'b0;
        a_cap   = 1'b0;
        check("t5_cc_count", 32'(a_count), 0);
        check("t5_cc_cv", 32'(a_cv), 0);
        check("t5_cc_captured", 32'(a_captured), 751);
        check("t5_cc_cov", 32'(a_cov), 1);
        for (int i = 1; i <= 5; i++) tick();
        check("t5_count5", 32'(a_count), 5);
        reset = 1'b1;
        a_cap = 1'b1;
        tick();
        reset = 1'b0;
        a_cap = 1'b0;
        check("t5_rst_count", 32'(a_count), 0);
        check("t5_rst_captured", 32'(a_captured), 0);
        check("t5_rst_cov", 32'(a_cov), 0);
        check("t5_rst_cv", 32'(a_cv), 0);
        check("t5_rst_ovf", 32'(a_ovf), 0);

        // enable=0 holds the count
        tick();
        tick();
        check("en_count2", 32'(a_count), 2);
        a_en = 1'b0;
        tick();
        tick();
        check("en_hold", 32'(a_count), 2);

        // T3: wrap mode, limit 4, period 5
        b_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("t3_count", 32'(b_count), i % 5);
            check("t3_wp", 32'(b_wp), (i % 5 == 0) ? 1 : 0);
            check("t3_ovf", 32'(b_ovf), 0);
        end
        b_en = 1'b0;
        tick();
        check("t3_idle_count", 32'(b_count), 0);
        check("t3_idle_wp", 32'(b_wp), 0);
        b_limit = 10'd0;
        b_en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_lim0_count", 32'(b_count), 0);
            check("t3_lim0_wp", 32'(b_wp), 1);
        end
        b_limit = 10'd4;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t3_relim_count", 32'(b_count), i);
            check("t3_relim_wp", 32'(b_wp), 0);
        end
        b_limit = 10'd1;
        tick();
        check("t3_lower_count", 32'(b_count), 0);
        check("t3_lower_wp", 32'(b_wp), 1);
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        check("t3_clear_count", 32'(b_count), 0);
        check("t3_clear_wp", 32'(b_wp), 0);
        b_en = 1'b0;

        // T6: WIDTH=4, limit all-ones, no overflow, no carry
        c_en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("t6_count", 32'(c_count), i);
            check("t6_ovf", 32'(c_ovf), 0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_hold_count", 32'(c_count), 15);
            check("t6_hold_ovf", 32'(c_ovf), 0);
        end
        c_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
